fpu_div_iter: RTL
=================

Name: fpu_div_iter

Overview:
- Iterative IEEE-754 single-precision divider; the responder (slave) end of the AXI4-Stream operand/result interface the FPU dispatcher drives.
- Drop-in replacement for the vendor divide core at the dispatcher's DIV slot, with identical port names and handshake semantics.
- Computes c = a / b with round-to-nearest-even and flush-to-zero.
- Fixed, operand-independent latency.

Parameters:
- BITS_PER_CYCLE, default 1: quotient bits per iteration cycle; legal values 1 or 2. Iteration count N_IT = ceil(26/BITS_PER_CYCLE).

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  reset; one clock; asynchronous, active-low.
- s_axis_a_tvalid  in  1  dividend valid.
- s_axis_a_tready  out  1  dividend ready.
- s_axis_a_tdata  in  32  dividend, IEEE single.
- s_axis_b_tvalid  in  1  divisor valid.
- s_axis_b_tready  out  1  divisor ready.
- s_axis_b_tdata  in  32  divisor, IEEE single.
- m_axis_result_tvalid  out  1  quotient valid.
- m_axis_result_tready  in  1  downstream ready.
- m_axis_result_tdata  out  32  quotient, IEEE single.

Behaviour:
- States: IDLE, UNPACK, ITER, ROUND, HOLD.
- Reset (aresetn low, asynchronous, any state): state IDLE; m_axis_result_tvalid 0; m_axis_result_tdata 0; iteration counter 0. An in-flight operation is discarded and produces no output.
- Ready outputs:
  - s_axis_a_tready = s_axis_b_tready = 1 only in IDLE with aresetn high; 0 in all other states.
- Accept (joint handshake):
  - Occurs on a rising edge in IDLE when both s_axis_a_tvalid and s_axis_b_tvalid are 1.
  - Both operands are captured on that edge. Next state: UNPACK.
  - If only one tvalid is high, nothing is captured and the state stays IDLE.
- UNPACK (1 cycle):
  - Split sign, exponent and mantissa. Exponent 0 is treated as zero (denormals flushed). Implicit 1 restored: 24-bit mantissas ma, mb.
  - If ma < mb: ma shifted left 1 and exponent decremented.
  - Special-case flag and special result latched.
  - Next state: ITER.
- ITER (N_IT cycles):
  - Restoring division, BITS_PER_CYCLE quotient bits per cycle, MSB first. Produces a 26-bit quotient (24 significand bits, guard, round).
  - Sticky = final remainder != 0.
  - Specials also spend these cycles, so latency is uniform.
  - Next state: ROUND.
- ROUND (1 cycle):
  - Increment when guard & (round | sticky | lsb). Mantissa carry-out renormalises and increments the exponent.
  - Biased exponent e = ea - eb + 127 (after adjustments). e >= 255 gives signed infinity; e <= 0 gives signed zero.
  - Sign = sa XOR sb.
- Latency: m_axis_result_tvalid rises on the edge N_IT+3 edges after the accept edge (29 for BITS_PER_CYCLE=1, 16 for 2). Data is registered on that same edge.
- HOLD:
  - tvalid = 1; tdata stable until m_axis_result_tready = 1 is sampled on a rising edge.
  - On that edge: tvalid goes to 0, state goes to IDLE. Input ready rises in the following cycle; no accept coincides with the result handshake.
  - tready asserted earlier than HOLD has no effect.
- Specials, with priority top-down:
  - Either operand NaN, 0/0, or inf/inf: 0x7FC00000.
  - inf/x: signed infinity.
  - x/0, x nonzero: signed infinity.
  - x/inf: signed zero.
  - 0/x: signed zero.
- At most one operation in flight. No exception flag outputs.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), BITS_PER_CYCLE=1, result tready tied 1 -> tdata 0x40400000; tvalid exactly 29 edges after accept, high for 1 cycle; s_tready 0 throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up path). 0x3F800000 / 0xC0000000 -> 0xBF000000. Repeat both with BITS_PER_CYCLE=2 -> same data, latency 16.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0xBF800000 / 0x00000000 -> 0xFF800000.
  - 0x00000000 / 0x00000000 -> 0x7FC00000.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000.
  - 0x3F800000 / 0x7F800000 -> 0x00000000.
  - Denormal 0x00000001 / 0x3F800000 -> 0x00000000.
  - All at full latency.
- Range: 0x7F7FFFFF / 0x00800000 -> 0x7F800000 (overflow). 0x00800000 / 0x7F7FFFFF -> 0x00000000 (underflow flush).
- Handshake:
  - Only a_tvalid high for 10 cycles -> no accept, readies stay 1.
  - Result tready held 0 for 7 cycles after tvalid -> tvalid/tdata stable; s_tready 0 until one cycle after the result handshake; a back-to-back second operation is then accepted.
- Reset mid-operation: aresetn pulled low asynchronously at iteration 10 -> tvalid 0 and tdata 0 immediately, with no clock edge required. After release, readies are 1, the aborted result never appears, and a new 6/2 yields 0x40400000 at normal latency.

Source files
------------

// File: rtl/fpu_div_iter.sv
// Iterative IEEE-754 single-precision divider (round-to-nearest-even, flush-to-zero)
// with AXI4-Stream operand/result handshakes and fixed, operand-independent latency.
module fpu_div_iter #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_a_tvalid,
   output logic        s_axis_a_tready,
   input  logic [31:0] s_axis_a_tdata,
   input  logic        s_axis_b_tvalid,
   output logic        s_axis_b_tready,
   input  logic [31:0] s_axis_b_tdata,
   output logic        m_axis_result_tvalid,
   input  logic        m_axis_result_tready,
   output logic [31:0] m_axis_result_tdata
);

   localparam int N_IT = (26 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int CW   = $clog2(N_IT + 1);

   typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, HOLD} state_t;

   state_t               state_q, state_d;
   logic [31:0]          a_q, b_q;
   logic [25:0]          rem_q;
   logic [23:0]          div_q;
   logic [25:0]          quo_q;
   logic signed [9:0]    exp_q;
   logic                 sign_q;
   logic                 spec_q;
   logic [31:0]          spec_res_q;
   logic [31:0]          res_q;
   logic [CW-1:0]        cnt_q;
   logic                 tvalid_q;
   logic [31:0]          tdata_q;

   // ---------------- control FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      else          state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (s_axis_a_tvalid && s_axis_b_tvalid) state_d = UNPACK;
         UNPACK:  state_d = ITER;
         ITER:    if (cnt_q == CW'(N_IT - 1)) state_d = ROUND;
         ROUND:   state_d = HOLD;
         HOLD:    if (tvalid_q && m_axis_result_tready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign s_axis_a_tready      = (state_q == IDLE) && aresetn;
   assign s_axis_b_tready      = (state_q == IDLE) && aresetn;
   assign m_axis_result_tvalid = tvalid_q;
   assign m_axis_result_tdata  = tdata_q;

   // ---------------- unpack ----------------
   logic [7:0]        ea, eb;
   logic [23:0]       ma, mb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, lt, sign_u;
   logic signed [9:0] exp_u;
   logic              spec_hit;
   logic [31:0]       spec_val;

   always_comb begin
      ea     = a_q[30:23];
      eb     = b_q[30:23];
      a_zero = (ea == 8'd0);
      b_zero = (eb == 8'd0);
      a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
      a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
      ma     = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
      mb     = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
      lt     = (ma < mb);
      sign_u = a_q[31] ^ b_q[31];
      exp_u  = 10'(ea) - 10'(eb) + 10'd127 - 10'(lt);

      spec_hit = 1'b1;
      spec_val = 32'd0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_val = 32'h7FC0_0000;
      else if (a_inf || b_zero)                                     spec_val = {sign_u, 8'hFF, 23'd0};
      else if (b_inf || a_zero)                                     spec_val = {sign_u, 31'd0};
      else                                                          spec_hit = 1'b0;
   end

   // ---------------- restoring division step(s) ----------------
   logic [25:0] rem_n, quo_n;

   always_comb begin
      rem_n = rem_q;
      quo_n = quo_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (rem_n >= {2'b00, div_q}) begin
            rem_n = rem_n - {2'b00, div_q};
            quo_n = {quo_n[24:0], 1'b1};
         end else begin
            quo_n = {quo_n[24:0], 1'b0};
         end
         rem_n = rem_n << 1;
      end
   end

   // ---------------- round and pack ----------------
   logic              inc;
   logic [24:0]       mant_r;
   logic signed [9:0] exp_r;
   logic [22:0]       frac_r;
   logic [31:0]       res_r;

   always_comb begin
      // quo_q = 24 significand bits, guard, round; sticky is any remainder left over
      inc    = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
      mant_r = {1'b0, quo_q[25:2]} + 25'(inc);
      exp_r  = exp_q + 10'(mant_r[24]);
      frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      if (spec_q)                  res_r = spec_res_q;
      else if (exp_r >= 10'sd255)  res_r = {sign_q, 8'hFF, 23'd0};
      else if (exp_r <= 10'sd0)    res_r = {sign_q, 31'd0};
      else                         res_r = {sign_q, exp_r[7:0], frac_r};
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         quo_q      <= '0;
         exp_q      <= '0;
         sign_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         tvalid_q   <= 1'b0;
         tdata_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (s_axis_a_tvalid && s_axis_b_tvalid) begin
                  a_q <= s_axis_a_tdata;
                  b_q <= s_axis_b_tdata;
               end
            end
            UNPACK: begin
               // a smaller dividend mantissa is pre-shifted so the quotient MSB is always 1
               rem_q      <= lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
               div_q      <= mb;
               quo_q      <= '0;
               exp_q      <= exp_u;
               sign_q     <= sign_u;
               spec_q     <= spec_hit;
               spec_res_q <= spec_val;
               cnt_q      <= '0;
            end
            ITER: begin
               rem_q <= rem_n;
               quo_q <= quo_n;
               cnt_q <= cnt_q + CW'(1);
            end
            ROUND: res_q <= res_r;
            HOLD: begin
               // first HOLD cycle presents the packed result; it then waits for the consumer
               if (!tvalid_q) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= res_q;
               end else if (m_axis_result_tready) begin
                  tvalid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
